// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter that shares one i2c_master between NUM_REQ requesters, one whole transaction at a time.
// Optional watchdog: define I2C_ARB_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES and drain the master.
module i2c_bus_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int MAX_BYTES      = 3,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ-1:0]                    req_rd_nwr,
    input  logic [NUM_REQ*7-1:0]                  req_addr,
    input  logic [NUM_REQ*$clog2(MAX_BYTES+1)-1:0] req_bytes,
    input  logic [NUM_REQ*MAX_BYTES*8-1:0]        req_din,
    output logic [NUM_REQ-1:0]                    grant,
    output logic [NUM_REQ-1:0]                    rsp_done,
    output logic                                  rsp_error,
    output logic [MAX_BYTES*8-1:0]                rsp_dout,
    output logic                                  m_start,
    output logic                                  m_rd_nwr,
    output logic [6:0]                            m_slave_addr,
    output logic [$clog2(MAX_BYTES+1)-1:0]        m_bytes_num,
    output logic [MAX_BYTES*8-1:0]                m_din,
    input  logic [MAX_BYTES*8-1:0]                m_dout,
    input  logic                                  m_done,
    input  logic                                  m_error
);
    localparam int BW = $clog2(MAX_BYTES + 1);
    localparam int IW = $clog2(NUM_REQ);
    localparam int DW = MAX_BYTES * 8;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("i2c_bus_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;
    logic [CW-1:0] cnt;
`else
    typedef enum logic [1:0] {IDLE, WAIT} state_t;
`endif

    state_t        state;
    logic [IW-1:0] last_owner;
    logic [IW-1:0] owner;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    int            j;

    // Scan last_owner+1, last_owner+2, ... with wrap; the first requester found wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        j          = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = int'(last_owner) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!pick_valid && req_valid[j[IW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = j[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            last_owner   <= IW'(NUM_REQ - 1);
            owner        <= '0;
            grant        <= '0;
            rsp_done     <= '0;
            rsp_error    <= 1'b0;
            rsp_dout     <= '0;
            m_start      <= 1'b0;
            m_rd_nwr     <= 1'b0;
            m_slave_addr <= '0;
            m_bytes_num  <= '0;
            m_din        <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt          <= '0;
`endif
        end else begin
            m_start  <= 1'b0;
            rsp_done <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        m_rd_nwr     <= req_rd_nwr[pick_idx];
                        m_slave_addr <= req_addr[pick_idx*7 +: 7];
                        m_bytes_num  <= req_bytes[pick_idx*BW +: BW];
                        m_din        <= req_din[pick_idx*DW +: DW];
                        grant        <= NUM_REQ'(1) << pick_idx;
                        owner        <= pick_idx;
                        m_start      <= 1'b1;
                        state        <= WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
                        cnt          <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (m_done) begin
                        rsp_done   <= grant;
                        rsp_dout   <= m_dout;
                        rsp_error  <= m_error;
                        grant      <= '0;
                        last_owner <= owner;
                        state      <= IDLE;
                    end
`ifdef I2C_ARB_TIMEOUT_EN
                    // Watchdog expiry: report failure to the owner, then let the master finish unobserved.
                    else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        rsp_done   <= grant;
                        rsp_dout   <= '0;
                        rsp_error  <= 1'b1;
                        grant      <= '0;
                        last_owner <= owner;
                        cnt        <= '0;
                        state      <= DRAIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
`ifdef I2C_ARB_TIMEOUT_EN
                DRAIN: begin
                    if (m_done || cnt == CW'(TIMEOUT_CYCLES - 1)) state <= IDLE;
                    else cnt <= cnt + 1'b1;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares one i2c_master instance (MAX_BYTES_PER_TRANSACTION bytes, 7-bit address) between NUM_REQ independent transaction requesters. Example requesters: the IR-sensor ADC sequencer and a second I2C peripheral controller.
- Round-robin grant, one whole transaction at a time.
- Latches the winner's command fields, pulses the master start, and routes done/read data/error back to the owning requester only.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- MAX_BYTES, 3, bytes per transaction; must match the master's MAX_BYTES_PER_TRANSACTION.
- TIMEOUT_CYCLES, 2500000, watchdog limit in clk cycles (used only with I2C_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester transaction request, level; hold stable until own rsp_done.
- req_rd_nwr  in  NUM_REQ  per-requester 1=read, 0=write.
- req_addr  in  NUM_REQ*7  per-requester slave address; requester i in bits [7i+6:7i].
- req_bytes  in  NUM_REQ*$clog2(MAX_BYTES+1)  per-requester byte count, 1..MAX_BYTES.
- req_din  in  NUM_REQ*MAX_BYTES*8  per-requester write bytes; byte 0 in the MSBs of each slice.
- grant  out  NUM_REQ  one-hot owner of the bus; all zero when idle.
- rsp_done  out  NUM_REQ  one-cycle completion pulse to the owner.
- rsp_error  out  1  error status, valid with rsp_done.
- rsp_dout  out  MAX_BYTES*8  read bytes, valid with rsp_done, held until the next completion.
- m_start  out  1  one-cycle pulse to master transaction_start.
- m_rd_nwr  out  1  to master.
- m_slave_addr  out  7  to master.
- m_bytes_num  out  $clog2(MAX_BYTES+1)  to master.
- m_din  out  MAX_BYTES*8  to master.
- m_dout  in  MAX_BYTES*8  from master.
- m_done  in  1  from master transaction_done.
- m_error  in  1  from master error.

Behaviour:
- Reset values:
  - grant=0, rsp_done=0, rsp_error=0, rsp_dout=0, m_start=0, m_rd_nwr=0, m_slave_addr=0, m_bytes_num=0, m_din=0.
  - last_owner=NUM_REQ-1, so requester 0 has first priority.
  - state=IDLE.
- All outputs are registered. rsp_done and m_start default to 0 every cycle.
- IDLE:
  - If any req_valid is high, choose the first set bit scanning last_owner+1, last_owner+2, ... with wrap-around.
  - Latch that requester's rd_nwr, addr, bytes and din onto the m_* outputs. Set grant one-hot and m_start=1, then go to WAIT.
  - m_start is therefore high the cycle after the request is sampled.
  - m_done seen in IDLE is ignored.
- WAIT:
  - m_* fields are held constant.
  - On m_done: rsp_done[owner]=1, rsp_dout=m_dout, rsp_error=m_error, grant=0, last_owner=owner, then go to IDLE.
- Requester handshake rules:
  - The requester clears req_valid on the clock edge at which it samples rsp_done high.
  - If req_valid stays high, the requester is re-queued behind the others in round-robin order.
  - A req_valid drop during WAIT does not cancel the transaction; rsp_done is still pulsed.
- Fairness: with all NUM_REQ requesting continuously, grants rotate 0,1,...,NUM_REQ-1,0. Minimum gap between m_done and the next m_start is 1 cycle.
- Write transactions return rsp_dout=m_dout unchanged; the requester ignores it.
- Reset asserted mid-transaction returns to IDLE immediately with all outputs at reset values. The master shares the same reset.

Optional Feature:
- Macro: I2C_ARB_TIMEOUT_EN.
- With the macro defined, a cycle counter runs in WAIT and clears on entry to WAIT.
  - If it reaches TIMEOUT_CYCLES-1 before m_done: rsp_done[owner]=1, rsp_error=1, rsp_dout=0, grant=0, go to DRAIN.
  - DRAIN issues no grant. It returns to IDLE on m_done (data discarded, no rsp_done) or after another TIMEOUT_CYCLES cycles.
  - last_owner is updated on timeout.
- Without the macro: no counter and no DRAIN state; WAIT lasts until m_done indefinitely.

Test Plan:
- Single request: req_valid[0]=1, write, addr 7'h48, bytes=3, din=24'h01C363 -> next cycle grant=2'b01, m_start one-cycle pulse, m_slave_addr=7'h48, m_din=24'h01C363. Master m_done with m_dout=24'h123400 -> rsp_done[0] one cycle later, rsp_dout=24'h123400, rsp_error=0, grant=0.
- Simultaneous requests from 0 and 1 after reset -> 0 served first, then 1. Requester 0 re-requests immediately -> order 0,1,0,1; never two consecutive grants to the same requester while the other is waiting.
- Field isolation: requester 1 changes req_addr from 7'h48 to 7'h29 during its own WAIT -> m_slave_addr stays 7'h48 until m_done.
- m_error=1 with m_done on requester 1's read -> rsp_done[1]=1, rsp_error=1, rsp_done[0] stays 0.
- Reset asserted in WAIT -> same cycle grant=0 and m_start=0; after release, a pending req_valid[1] is not granted before requester 0 if both request.
- I2C_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=100, no m_done -> rsp_done with rsp_error=1 exactly 100 cycles after entering WAIT. A late m_done in DRAIN produces no rsp_done; the next request is granted only after DRAIN exits.
